// File: rtl/layer_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_mem_pkg
// Purpose  : Shared constants, types and helpers for the double-buffered
//            layer result store (bank index type, depth/address-width
//            helpers, linear row/col address computation).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package layer_mem_pkg;

    // One bit selects between the two ping-pong banks.
    typedef logic bank_idx_t;

    localparam bank_idx_t c_bank_0 = 1'b0;

    // Words per bank for an h x w frame.
    function automatic int unsigned calc_depth(input int unsigned h, input int unsigned w);
        return h * w;
    endfunction

    // Address width for a bank of the given depth, never below one bit.
    function automatic int unsigned calc_aw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // row*width + col evaluated at full width; the caller truncates to AW.
    function automatic logic [63:0] lin_addr(input logic [31:0]  row,
                                             input logic [31:0]  col,
                                             input int unsigned  width);
        return ({32'd0, row} * 64'(width)) + {32'd0, col};
    endfunction

endpackage : layer_mem_pkg
`default_nettype wire

// File: rtl/layer_result_bank.sv
`default_nettype none
// ============================================================================
// Module   : layer_result_bank
// Purpose  : One frame bank: behavioural array with a synchronous write
//            port and a synchronous (registered) read port. Contents and the
//            read register are not reset.
// Ports    : clk      - clock, rising edge
//            wr_en    - write strobe
//            wr_addr  - write word address
//            wr_data  - write data
//            rd_en    - read strobe; rd_data updates on the next edge
//            rd_addr  - read word address
//            rd_data  - registered read data (holds when rd_en is low)
// Revision : 1.0 - initial release
// ============================================================================
module layer_result_bank
    import layer_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 196,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : layer_result_bank
`default_nettype wire

// File: rtl/layer_result_pingpong_mem.sv
`default_nettype none
// ============================================================================
// Module   : layer_result_pingpong_mem
// Purpose  : Double-buffered FMAP_H x FMAP_W feature-map result store. The
//            producer fills one bank while the consumer reads the other;
//            banks change hands on accepted frame-done handshakes.
// Build    : define LAYER_MEM_BOUNDS_CHECK_EN to range-check row/col; out of
//            range writes are dropped, out of range reads return zero, and
//            either sets the sticky addr_err flag. Otherwise addr_err is 0
//            and the truncated linear address is used as-is.
// Ports    : clk            - clock, rising edge
//            rst            - asynchronous reset, active low
//            wr_en/wr_row/wr_col/wr_data - producer write
//            wr_frame_done  - producer finished current frame
//            wr_ready       - write bank free (writes/frame-done accepted)
//            rd_en/rd_row/rd_col - consumer read request
//            rd_frame_done  - consumer finished current frame
//            rd_frame_avail - read bank holds a complete frame
//            rd_data        - read data, one cycle after an accepted read
//            rd_valid       - rd_data is valid this cycle
//            addr_err       - sticky out-of-range access flag
// Revision : 1.0 - initial release
// ============================================================================
module layer_result_pingpong_mem
    import layer_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned FMAP_H  = 14,
    parameter int unsigned FMAP_W  = 14,
    parameter int unsigned COORD_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [COORD_W-1:0] wr_row,
    input  logic [COORD_W-1:0] wr_col,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_frame_done,
    output logic               wr_ready,
    input  logic               rd_en,
    input  logic [COORD_W-1:0] rd_row,
    input  logic [COORD_W-1:0] rd_col,
    input  logic               rd_frame_done,
    output logic               rd_frame_avail,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               addr_err
);

    localparam int unsigned c_depth = calc_depth(FMAP_H, FMAP_W);
    localparam int unsigned c_aw    = calc_aw(c_depth);

    // ------------------------------------------------------------------
    // Bank ownership state
    // ------------------------------------------------------------------
    bank_idx_t         r_wr_bank;
    bank_idx_t         r_rd_bank;
    logic [1:0]        r_full;
    logic [1:0]        w_full_next;

    logic              w_wr_ready;
    logic              w_rd_avail;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_done;
    logic              w_rd_done;
    logic              w_wr_store;

    logic [c_aw-1:0]   w_wr_addr;
    logic [c_aw-1:0]   w_rd_addr;

    // Read return path
    logic              r_rd_valid;
    bank_idx_t         r_rd_sel;
    logic [DATA_W-1:0] r_rd_hold;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_bank_rdata [2];

    assign w_wr_ready = !r_full[r_wr_bank];
    assign w_rd_avail = r_full[r_rd_bank];

    assign w_wr_acc   = wr_en && w_wr_ready;
    assign w_rd_acc   = rd_en && w_rd_avail;
    assign w_wr_done  = wr_frame_done && w_wr_ready;
    assign w_rd_done  = rd_frame_done && w_rd_avail;

    assign w_wr_addr  = c_aw'(lin_addr(32'(wr_row), 32'(wr_col), FMAP_W));
    assign w_rd_addr  = c_aw'(lin_addr(32'(rd_row), 32'(rd_col), FMAP_W));

    // The producer only finishes an EMPTY bank and the consumer only frees a
    // FULL one, so the two updates can never target the same flag.
    always_comb begin
        w_full_next = r_full;
        if (w_wr_done) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_bank <= c_bank_0;
            r_rd_bank <= c_bank_0;
            r_full    <= 2'b00;
        end else begin
            r_full <= w_full_next;
            if (w_wr_done) begin
                r_wr_bank <= !r_wr_bank;
            end
            if (w_rd_done) begin
                r_rd_bank <= !r_rd_bank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional range checking
    // ------------------------------------------------------------------
`ifdef LAYER_MEM_BOUNDS_CHECK_EN
    localparam logic [COORD_W-1:0] c_fmap_h = COORD_W'(FMAP_H);
    localparam logic [COORD_W-1:0] c_fmap_w = COORD_W'(FMAP_W);

    logic w_wr_oob;
    logic w_rd_oob;
    logic r_rd_zero;
    logic r_addr_err;

    assign w_wr_oob   = (wr_row >= c_fmap_h) || (wr_col >= c_fmap_w);
    assign w_rd_oob   = (rd_row >= c_fmap_h) || (rd_col >= c_fmap_w);
    assign w_wr_store = w_wr_acc && !w_wr_oob;

    // An out-of-range read still returns a beat, forced to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_zero  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rd_zero <= w_rd_oob;
            end
            if ((w_wr_acc && w_wr_oob) || (w_rd_acc && w_rd_oob)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign w_rd_word = r_rd_zero ? '0 : w_bank_rdata[r_rd_sel];
    assign addr_err  = r_addr_err;
`else
    assign w_wr_store = w_wr_acc;
    assign w_rd_word  = w_bank_rdata[r_rd_sel];
    assign addr_err   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        layer_result_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (c_depth),
            .AW     (c_aw)
        ) u_bank (
            .clk     (clk),
            .wr_en   (w_wr_store && (r_wr_bank == 1'(gi))),
            .wr_addr (w_wr_addr),
            .wr_data (wr_data),
            .rd_en   (w_rd_acc && (r_rd_bank == 1'(gi))),
            .rd_addr (w_rd_addr),
            .rd_data (w_bank_rdata[gi])
        );
    end

    // ------------------------------------------------------------------
    // Read return: remember which bank served the read, since rd_bank may
    // toggle in the same cycle the read is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_sel   <= c_bank_0;
            r_rd_hold  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_sel <= r_rd_bank;
            end
            r_rd_hold <= rd_data;
        end
    end

    // Between beats the output keeps the last delivered word.
    assign rd_data        = r_rd_valid ? w_rd_word : r_rd_hold;
    assign rd_valid       = r_rd_valid;
    assign wr_ready       = w_wr_ready;
    assign rd_frame_avail = w_rd_avail;

endmodule : layer_result_pingpong_mem
`default_nettype wire

// File: tb/tb_layer_result_pingpong_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_result_pingpong_mem
// Purpose  : Self-checking bench for layer_result_pingpong_mem: reference
//            model of bank flags/pointers/contents, a read scoreboard queue,
//            a vector table for the first frame and hand-written sequences
//            for ping-pong, back-pressure, same-cycle handshakes, range
//            checking and reset during a read burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_result_pingpong_mem;

    localparam int DW = 128;
    localparam int H  = 14;
    localparam int W  = 14;
    localparam int D  = H * W;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [15:0]   wr_row;
    logic [15:0]   wr_col;
    logic [DW-1:0] wr_data;
    logic          wr_frame_done;
    logic          wr_ready;
    logic          rd_en;
    logic [15:0]   rd_row;
    logic [15:0]   rd_col;
    logic          rd_frame_done;
    logic          rd_frame_avail;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          addr_err;

    layer_result_pingpong_mem #(
        .DATA_W  (DW),
        .FMAP_H  (H),
        .FMAP_W  (W),
        .COORD_W (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_row         (wr_row),
        .wr_col         (wr_col),
        .wr_data        (wr_data),
        .wr_frame_done  (wr_frame_done),
        .wr_ready       (wr_ready),
        .rd_en          (rd_en),
        .rd_row         (rd_row),
        .rd_col         (rd_col),
        .rd_frame_done  (rd_frame_done),
        .rd_frame_avail (rd_frame_avail),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .addr_err       (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [DW-1:0] m_mem [2][D];
    bit            m_full [2];
    bit            m_wb;
    bit            m_rb;
    bit            m_err;
    logic [DW-1:0] m_last;
    logic [DW-1:0] exp_q [$];

`ifdef LAYER_MEM_BOUNDS_CHECK_EN
    localparam bit c_chk = 1'b1;
`else
    localparam bit c_chk = 1'b0;
`endif

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_wb      = 1'b0;
        m_rb      = 1'b0;
        m_err     = 1'b0;
        m_last    = '0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic exp_valid;
        exp_valid = (exp_q.size() > 0);
        if (exp_valid) begin
            m_last = exp_q.pop_front();
        end
        chk("rd_valid", DW'(rd_valid), DW'(exp_valid));
        chk("rd_data", rd_data, m_last);
        chk("wr_ready", DW'(wr_ready), DW'(!m_full[m_wb]));
        chk("rd_frame_avail", DW'(rd_frame_avail), DW'(m_full[m_rb]));
        chk("addr_err", DW'(addr_err), DW'(m_err));
    endtask

    // One clock: drive at posedge+1, model the edge, check at next posedge+1.
    task automatic cyc(input bit we, input int wr, input int wc, input logic [DW-1:0] wd,
                       input bit wfd, input bit re, input int rr, input int rc, input bit rfd);
        bit w_rdy;
        bit avail;
        bit woob;
        bit roob;
        int wa;
        int ra;
        wr_en         = we;
        wr_row        = 16'(wr);
        wr_col        = 16'(wc);
        wr_data       = wd;
        wr_frame_done = wfd;
        rd_en         = re;
        rd_row        = 16'(rr);
        rd_col        = 16'(rc);
        rd_frame_done = rfd;
        w_rdy = !m_full[m_wb];
        avail = m_full[m_rb];
        wa    = wr * W + wc;
        ra    = rr * W + rc;
        woob  = (wr >= H) || (wc >= W);
        roob  = (rr >= H) || (rc >= W);
        @(posedge clk);
        if (we && w_rdy) begin
            if (c_chk && woob) m_err = 1'b1;
            else if (wa < D) m_mem[m_wb][wa] = wd;
        end
        if (re && avail) begin
            if (c_chk && roob) begin
                m_err = 1'b1;
                exp_q.push_back('0);
            end else begin
                exp_q.push_back(m_mem[m_rb][ra]);
            end
        end
        if (wfd && w_rdy) begin
            m_full[m_wb] = 1'b1;
            m_wb = !m_wb;
        end
        if (rfd && avail) begin
            m_full[m_rb] = 1'b0;
            m_rb = !m_rb;
        end
        #1;
        wr_en         = 1'b0;
        wr_frame_done = 1'b0;
        rd_en         = 1'b0;
        rd_frame_done = 1'b0;
        check_outputs();
    endtask

    typedef struct {
        bit            we;
        int            wr;
        int            wc;
        logic [DW-1:0] wd;
        bit            wfd;
        bit            re;
        int            rr;
        int            rc;
        bit            rfd;
        bit            e_wr_ready;
        bit            e_avail;
        bit            e_valid;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vt [6];

    localparam logic [DW-1:0] c_a = 128'hA5A5_0000_1111_2222_3333_4444_5555_A5A5;
    localparam logic [DW-1:0] c_b = 128'h0BB0_DEAD_BEEF_0123_4567_89AB_CDEF_0BB0;

    initial begin
        // Table: write (0,0)=A, (13,13)=B, frame done, read both back, release.
        vt[0] = '{1, 0,  0,  c_a, 0, 0, 0,  0,  0, 1, 0, 0, '0};
        vt[1] = '{1, 13, 13, c_b, 0, 0, 0,  0,  0, 1, 0, 0, '0};
        vt[2] = '{0, 0,  0,  '0,  1, 0, 0,  0,  0, 1, 1, 0, '0};
        vt[3] = '{0, 0,  0,  '0,  0, 1, 13, 13, 0, 1, 1, 1, c_b};
        vt[4] = '{0, 0,  0,  '0,  0, 1, 0,  0,  0, 1, 1, 1, c_a};
        vt[5] = '{0, 0,  0,  '0,  0, 0, 0,  0,  1, 1, 0, 0, c_a};

        rst = 1'b0;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; wr_frame_done = 1'b0;
        rd_en = 1'b0; rd_row = '0; rd_col = '0; rd_frame_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", DW'(rd_valid), '0);
        chk("reset_rd_data", rd_data, '0);
        chk("reset_wr_ready", DW'(wr_ready), DW'(1));
        chk("reset_rd_avail", DW'(rd_frame_avail), '0);
        chk("reset_addr_err", DW'(addr_err), '0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cyc(vt[i].we, vt[i].wr, vt[i].wc, vt[i].wd, vt[i].wfd,
                vt[i].re, vt[i].rr, vt[i].rc, vt[i].rfd);
            chk($sformatf("vec%0d_wr_ready", i), DW'(wr_ready), DW'(vt[i].e_wr_ready));
            chk($sformatf("vec%0d_avail", i), DW'(rd_frame_avail), DW'(vt[i].e_avail));
            chk($sformatf("vec%0d_valid", i), DW'(rd_valid), DW'(vt[i].e_valid));
            chk($sformatf("vec%0d_data", i), rd_data, vt[i].e_data);
        end

        // Ping-pong: two full frames, then back-pressure.
        for (int a = 0; a < D; a++) cyc(1, a / W, a % W, DW'(a), 0, 0, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 0, 0, 0, 0);
        for (int a = 0; a < D; a++) cyc(1, a / W, a % W, DW'(a + 1000), 0, 0, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 0, 0, 0, 0);
        chk("both_full_wr_ready", DW'(wr_ready), '0);
        for (int a = 0; a < D; a++) cyc(0, 0, 0, '0, 0, 1, a / W, a % W, 0);
        chk("frame0_last_word", rd_data, DW'(D - 1));
        cyc(0, 0, 0, '0, 0, 0, 0, 0, 1);
        chk("after_release_wr_ready", DW'(wr_ready), DW'(1));
        cyc(0, 0, 0, '0, 0, 1, 2, 3, 0);
        chk("frame1_word", rd_data, DW'(2 * W + 3 + 1000));

        // Third frame into the freed bank, then both full again.
        for (int a = 0; a < D; a++) cyc(1, a / W, a % W, DW'(a + 2000), 0, 0, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 0, 0, 0, 0);
        // Dropped write while back-pressured.
        cyc(1, 5, 7, 128'hDEAD, 0, 0, 0, 0, 0);
        // Read and release on the same cycle: data from the old bank.
        cyc(0, 0, 0, '0, 0, 1, 5, 7, 1);
        chk("same_cycle_old_bank", rd_data, DW'(5 * W + 7 + 1000));
        cyc(0, 0, 0, '0, 0, 1, 5, 7, 0);
        chk("next_read_new_bank", rd_data, DW'(5 * W + 7 + 2000));
        // Simultaneous producer and consumer frame-done.
        cyc(0, 0, 0, '0, 1, 0, 0, 0, 1);
        chk("simul_wr_ready", DW'(wr_ready), DW'(1));
        chk("simul_avail", DW'(rd_frame_avail), DW'(1));
        cyc(0, 0, 0, '0, 0, 1, 5, 7, 0);
        chk("dropped_write_bank0", rd_data, DW'(5 * W + 7 + 1000));
        cyc(0, 0, 0, '0, 0, 0, 0, 0, 1);
        // Read with nothing available.
        cyc(0, 0, 0, '0, 0, 1, 1, 1, 0);
        chk("no_avail_no_valid", DW'(rd_valid), '0);

        // Range handling (expectations depend on the build).
        cyc(1, 0, 0, 128'h55, 0, 0, 0, 0, 0);
        cyc(1, 14, 0, 128'h99, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, '0, 0, 1, 0, 14, 0);
        cyc(0, 0, 0, '0, 0, 1, 5, 7, 0);
        chk("dropped_write_bank1", rd_data, DW'(5 * W + 7 + 2000));
        cyc(0, 0, 0, '0, 0, 1, 0, 0, 0);
        chk("addr_err_sticky", DW'(addr_err), DW'(c_chk));

        // Reset in the middle of a read burst.
        cyc(0, 0, 0, '0, 0, 1, 1, 2, 0);
        cyc(0, 0, 0, '0, 0, 1, 1, 3, 0);
        rd_en  = 1'b1;
        rd_row = 16'd1;
        rd_col = 16'd4;
        #2;
        rst = 1'b0;
        rd_en = 1'b0;
        #1;
        model_reset();
        chk("midreset_rd_valid", DW'(rd_valid), '0);
        chk("midreset_wr_ready", DW'(wr_ready), DW'(1));
        chk("midreset_avail", DW'(rd_frame_avail), '0);
        chk("midreset_addr_err", DW'(addr_err), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 0, 0, '0, 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_layer_result_pingpong_mem
`default_nettype wire
